// File: rtl/ped_request_conditioner_if.sv
// Signal bundle between the push-button front end and the pedestrian light controller.
interface ped_request_conditioner_if;
  logic       button_raw;
  logic       ack;
  logic       button;
  logic       pressed;
  logic [7:0] press_count;

  modport master (
    output button_raw,
    output ack,
    input  button,
    input  pressed,
    input  press_count
  );

  modport slave (
    input  button_raw,
    input  ack,
    output button,
    output pressed,
    output press_count
  );
endinterface

// File: rtl/ped_request_conditioner.sv
// Synchronizes and debounces the pedestrian push-button, holds a request until acked,
// and counts accepted presses.
//
// state         | meaning
// IDLE          | debounced level low, waiting for a high sample
// COUNT_PRESS   | counting consecutive high samples
// PRESSED       | debounced level high
// COUNT_RELEASE | counting consecutive low samples
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 sys_clkp,
  input  logic                 rst_n,
  ped_request_conditioner_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt already holds the samples seen so far, so the final stable sample arrives at LAST
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    COUNT_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    COUNT_RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             sync_lvl;
  logic             button_q;
  logic [7:0]       count_q;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sys_clkp) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      button_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.button_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // a fresh press beats a coincident ack
      if (accept) begin
        button_q <= 1'b1;
      end else if (bus.ack) begin
        button_q <= 1'b0;
      end
      if (accept && (count_q != 8'd255)) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_lvl) begin
          state_d = COUNT_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      COUNT_PRESS: begin
        if (!sync_lvl) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync_lvl) begin
          state_d = COUNT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      COUNT_RELEASE: begin
        if (sync_lvl) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.pressed     = (state_q == PRESSED) || (state_q == COUNT_RELEASE);
  assign bus.button      = button_q;
  assign bus.press_count = count_q;

endmodule
